// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MC_BUSY  = 2'd2
    } hz_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline, slave the controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_wb_load;
    logic [4:0]       ex_wb_rd;
    logic             ex_redirect;
    logic             ex_mc_start;
    logic             ex_mc_done;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wb_load, ex_wb_rd,
               ex_redirect, ex_mc_start, ex_mc_done, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               hz_state, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wb_load, ex_wb_rd,
               ex_redirect, ex_mc_start, ex_mc_done, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               hz_state, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator between the ID sources and the EX load destination.
module load_use_detect (
    input  logic       load,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = load && (rd != 5'd0) &&
                    ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: per-stage enables/flushes for memory waits, multicycle ops,
// redirects and load-use stalls, plus saturating stall/flush counters.
//
// state       | meaning
// ST_RUN      | normal flow; evaluates new hazards by priority
// ST_MEM_WAIT | data memory busy; pipeline frozen, redirects held in redirect_pending
// ST_MC_BUSY  | multicycle EX op in flight; front end held, bubbles into EX/MEM
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    pipeline_hazard_ctrl_if.slave    hz
);

    hz_state_t        state_q, state_d;
    logic             pend_q, pend_d;
    logic             lu_block_q;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic lu_hazard, lu_stall, redirect_apply;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;

    load_use_detect u_lu (
        .load    (hz.ex_wb_load),
        .rd      (hz.ex_wb_rd),
        .rs1     (hz.id_rs1),
        .rs2     (hz.id_rs2),
        .use_rs1 (hz.id_use_rs1),
        .use_rs2 (hz.id_use_rs2),
        .hazard  (lu_hazard)
    );

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        lu_stall       = 1'b0;
        redirect_apply = 1'b0;
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                    state_d = ST_MEM_WAIT;
                    if (hz.ex_redirect) pend_d = 1'b1;
                end else if (hz.ex_redirect) begin
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    redirect_apply = 1'b1;
                end else if (hz.ex_mc_start && !hz.ex_mc_done) begin
                    {pc_en, if_id_en, id_ex_en} = 3'b000;
                    ex_mem_flush = 1'b1;
                    state_d      = ST_MC_BUSY;
                end else if (lu_hazard && !lu_block_q) begin
                    // The bubble moves the load on; block a repeat stall next cycle.
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    lu_stall    = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                    if (hz.ex_redirect) pend_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                    if (pend_q || hz.ex_redirect) begin
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        redirect_apply = 1'b1;
                    end
                end
            end
            ST_MC_BUSY: begin
                if (!hz.ex_mc_done) begin
                    {pc_en, if_id_en, id_ex_en} = 3'b000;
                    ex_mem_flush = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase

        // While in reset the pipeline is held with bubbles in every register.
        if (!rst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en}   = 4'b0000;
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
            redirect_apply = 1'b0;
            lu_stall       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pend_q     <= 1'b0;
            lu_block_q <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            lu_block_q <= lu_stall;
            if (!pc_en)         stall_cnt <= sat_inc(stall_cnt);
            if (redirect_apply) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.hz_state     = state_q;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] en_v();
        return {hz_if.pc_en, hz_if.if_id_en, hz_if.id_ex_en, hz_if.ex_mem_en};
    endfunction

    function automatic logic [2:0] fl_v();
        return {hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        hz_if.id_rs1      = 5'd0;
        hz_if.id_rs2      = 5'd0;
        hz_if.id_use_rs1  = 1'b0;
        hz_if.id_use_rs2  = 1'b0;
        hz_if.ex_wb_load  = 1'b0;
        hz_if.ex_wb_rd    = 5'd0;
        hz_if.ex_redirect = 1'b0;
        hz_if.ex_mc_start = 1'b0;
        hz_if.ex_mc_done  = 1'b0;
        hz_if.mem_req     = 1'b0;
        hz_if.mem_ready   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_in();

        // reset values
        #1;
        chk("rst_en", 32'(en_v()), 32'h0);
        chk("rst_fl", 32'(fl_v()), 32'h7);
        chk("rst_state", 32'(hz_if.hz_state), 32'd0);
        chk("rst_stall", hz_if.stall_cycles, 32'd0);
        chk("rst_flush", hz_if.flush_count, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("run_en", 32'(en_v()), 32'hF);
        chk("run_fl", 32'(fl_v()), 32'h0);
        chk("run_state", 32'(hz_if.hz_state), 32'd0);

        // load-use on rs2, inputs held for two cycles: exactly one stall cycle
        @(negedge clk);
        hz_if.ex_wb_load = 1'b1; hz_if.ex_wb_rd = 5'd5;
        hz_if.id_rs2 = 5'd5; hz_if.id_use_rs2 = 1'b1;
        #1;
        chk("lu_en", 32'(en_v()), 32'h3);
        chk("lu_fl", 32'(fl_v()), 32'h2);
        @(negedge clk); #1;
        chk("lu_once_en", 32'(en_v()), 32'hF);
        chk("lu_once_fl", 32'(fl_v()), 32'h0);
        chk("lu_stall1", hz_if.stall_cycles, 32'd1);
        @(negedge clk); idle_in(); #1;
        chk("lu_stall_hold", hz_if.stall_cycles, 32'd1);

        // rd = x0 never stalls
        @(negedge clk);
        hz_if.ex_wb_load = 1'b1; hz_if.ex_wb_rd = 5'd0;
        hz_if.id_use_rs1 = 1'b1; hz_if.id_use_rs2 = 1'b1;
        #1;
        chk("x0_en", 32'(en_v()), 32'hF);
        // matching rs1 that is not read: no stall
        @(negedge clk);
        hz_if.ex_wb_rd = 5'd7; hz_if.id_rs1 = 5'd7; hz_if.id_use_rs1 = 1'b0;
        hz_if.id_rs2 = 5'd3; hz_if.id_use_rs2 = 1'b1;
        #1;
        chk("nouse_en", 32'(en_v()), 32'hF);
        chk("x0_stall", hz_if.stall_cycles, 32'd1);
        @(negedge clk);
        hz_if.id_use_rs1 = 1'b1;
        #1;
        chk("lu_rs1_en", 32'(en_v()), 32'h3);
        @(negedge clk); idle_in(); #1;
        chk("lu_rs1_stall", hz_if.stall_cycles, 32'd2);

        // memory wait with redirect in cycle 2
        @(negedge clk);
        hz_if.mem_req = 1'b1; hz_if.mem_ready = 1'b0;
        #1;
        chk("mw1_en", 32'(en_v()), 32'h0);
        chk("mw1_fl", 32'(fl_v()), 32'h0);
        @(negedge clk);
        hz_if.ex_redirect = 1'b1;
        #1;
        chk("mw2_state", 32'(hz_if.hz_state), 32'd1);
        chk("mw2_en", 32'(en_v()), 32'h0);
        chk("mw2_fl", 32'(fl_v()), 32'h0);
        @(negedge clk);
        hz_if.ex_redirect = 1'b0;
        #1;
        chk("mw3_en", 32'(en_v()), 32'h0);
        chk("mw3_flush_cnt", hz_if.flush_count, 32'd0);
        @(negedge clk);
        hz_if.mem_ready = 1'b1;
        #1;
        chk("mw_exit_en", 32'(en_v()), 32'hF);
        chk("mw_exit_fl", 32'(fl_v()), 32'h6);
        @(negedge clk); idle_in(); #1;
        chk("mw_done_state", 32'(hz_if.hz_state), 32'd0);
        chk("mw_done_fl", 32'(fl_v()), 32'h0);
        chk("mw_flush_cnt", hz_if.flush_count, 32'd1);
        chk("mw_stall", hz_if.stall_cycles, 32'd5);

        // redirect outranks a simultaneous load-use hazard
        @(negedge clk);
        hz_if.ex_redirect = 1'b1;
        hz_if.ex_wb_load = 1'b1; hz_if.ex_wb_rd = 5'd5;
        hz_if.id_rs2 = 5'd5; hz_if.id_use_rs2 = 1'b1;
        #1;
        chk("redir_en", 32'(en_v()), 32'hF);
        chk("redir_fl", 32'(fl_v()), 32'h6);
        @(negedge clk); idle_in(); #1;
        chk("redir_flush_cnt", hz_if.flush_count, 32'd2);
        chk("redir_stall", hz_if.stall_cycles, 32'd5);

        // multicycle op, done four cycles after start
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1;
        #1;
        chk("mc0_en", 32'(en_v()), 32'h1);
        chk("mc0_fl", 32'(fl_v()), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            hz_if.ex_mc_start = 1'b0;
            #1;
            chk("mc_busy_state", 32'(hz_if.hz_state), 32'd2);
            chk("mc_busy_fl", 32'(fl_v()), 32'h1);
        end
        @(negedge clk);
        hz_if.ex_mc_done = 1'b1;
        #1;
        chk("mc_exit_state", 32'(hz_if.hz_state), 32'd2);
        chk("mc_exit_en", 32'(en_v()), 32'hF);
        chk("mc_exit_fl", 32'(fl_v()), 32'h0);
        @(negedge clk); idle_in(); #1;
        chk("mc_done_state", 32'(hz_if.hz_state), 32'd0);
        chk("mc_stall", hz_if.stall_cycles, 32'd9);

        // start and done together: single-cycle op
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1; hz_if.ex_mc_done = 1'b1;
        #1;
        chk("mc1_en", 32'(en_v()), 32'hF);
        chk("mc1_fl", 32'(fl_v()), 32'h0);
        @(negedge clk); idle_in(); #1;
        chk("mc1_state", 32'(hz_if.hz_state), 32'd0);
        chk("mc1_stall", hz_if.stall_cycles, 32'd9);

        // saturation of stall_cycles
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        hz_if.mem_req = 1'b1; hz_if.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("sat_stall", hz_if.stall_cycles, 32'hFFFF_FFFF);
        hz_if.mem_ready = 1'b1;
        @(negedge clk); idle_in(); #1;
        chk("sat_hold", hz_if.stall_cycles, 32'hFFFF_FFFF);
        chk("sat_state", 32'(hz_if.hz_state), 32'd0);

        // reset in the middle of a multicycle op
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1;
        @(negedge clk);
        hz_if.ex_mc_start = 1'b0;
        #1;
        chk("rmc_state", 32'(hz_if.hz_state), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmc_rst_state", 32'(hz_if.hz_state), 32'd0);
        chk("rmc_rst_stall", hz_if.stall_cycles, 32'd0);
        chk("rmc_rst_flush", hz_if.flush_count, 32'd0);
        chk("rmc_rst_en", 32'(en_v()), 32'h0);
        chk("rmc_rst_fl", 32'(fl_v()), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rmc_after_state", 32'(hz_if.hz_state), 32'd0);
        chk("rmc_after_en", 32'(en_v()), 32'hF);
        chk("rmc_after_stall", hz_if.stall_cycles, 32'd0);

        // illegal state recovers to RUN on the next edge
        @(negedge clk);
        force dut.state_q = hz_state_t'(2'd3);
        #1;
        release dut.state_q;
        #1;
        chk("ill_state", 32'(hz_if.hz_state), 32'd3);
        @(negedge clk); #1;
        chk("ill_recover", 32'(hz_if.hz_state), 32'd0);
        chk("ill_en", 32'(en_v()), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have these ports: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have these ports: id_rs1 / id_rs2, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have these ports: id_use_rs1 / id_use_rs2, input, 1 each, the ID instruction reads that source.
REQ-005 SHALL have these ports: ex_wb_load, input, 1, the EX instruction is a load.
REQ-006 SHALL have these ports: ex_wb_rd, input, 5, destination register of the EX instruction.
REQ-007 SHALL have these ports: ex_redirect, input, 1, EX resolved a mispredict or jump, so the front end must be redirected.
REQ-008 SHALL have these ports: ex_mc_start / ex_mc_done, input, 1 each, the multicycle EX unit begins / finishes an operation.
REQ-009 SHALL have these ports: mem_req / mem_ready, input, 1 each, MEM-stage data access pending / data memory accepted-completed.
REQ-010 SHALL have these ports: pc_en, if_id_en, id_ex_en, ex_mem_en, output, 1 each, per-stage advance enables.
REQ-011 SHALL have these ports: if_id_flush, id_ex_flush, ex_mem_flush, output, 1 each, per-stage bubble inserts; a flush overrides the same register's enable.
REQ-012 SHALL have these ports: hz_state, output, 2, current FSM state.
REQ-013 SHALL have these ports: stall_cycles, output, 32, count of cycles with pc_en=0.
REQ-014 SHALL have these ports: flush_count, output, 32, count of applied redirects.

Function
REQ-015 SHALL implement FSM states RUN=0, MEM_WAIT=1, MC_BUSY=2; state 3 is illegal and returns to RUN on the next edge.
REQ-016 SHALL drive all enable and flush outputs combinationally from current state and inputs, with zero-cycle latency.
REQ-017 RUN, default: all enables=1 and all flushes=0.
REQ-018 RUN, priority 1, mem_req=1 and mem_ready=0: all enables=0 and all flushes=0; next state MEM_WAIT.
REQ-019 RUN, priority 2, ex_redirect=1: pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count+1.
REQ-020 RUN, priority 3, ex_mc_start=1 and ex_mc_done=0: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1; next state MC_BUSY.
REQ-021 RUN, priority 4, load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, for one cycle only.
REQ-022 Load-use hazard SHALL be defined as ex_wb_load=1, ex_wb_rd!=0, and ((id_use_rs1 and id_rs1==ex_wb_rd) or (id_use_rs2 and id_rs2==ex_wb_rd)).
REQ-023 MEM_WAIT: all enables=0 while mem_ready=0; ex_redirect asserted during MEM_WAIT SHALL be latched into redirect_pending, not acted on.
REQ-024 MEM_WAIT exit: on mem_ready=1, all enables=1 that cycle; next state RUN.
REQ-025 If redirect_pending=1 at MEM_WAIT exit, that exit cycle SHALL also assert if_id_flush and id_ex_flush, increment flush_count, and clear redirect_pending.
REQ-026 MC_BUSY: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1 each cycle until ex_mc_done=1.
REQ-027 MC_BUSY exit, on ex_mc_done=1: all enables=1 and no flush; next state RUN.
REQ-028 ex_mc_start and ex_mc_done both high in RUN SHALL be treated as a single-cycle op, with no stall.
REQ-029 stall_cycles SHALL increment on every cycle with pc_en=0 and saturate at 0xFFFFFFFF.
REQ-030 flush_count SHALL increment on every applied redirect and saturate at 0xFFFFFFFF.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=RUN, redirect_pending=0, stall_cycles=0, flush_count=0.
REQ-032 While rst_n=0, outputs SHALL be: enables=0, flushes=1.
REQ-033 Reset during MEM_WAIT or MC_BUSY SHALL discard the pending operation and any latched redirect.
REQ-034 The first edge after rst_n rises SHALL be in RUN.

Structure
REQ-035 The state encodings and the counter width SHALL live in the shared core package.
REQ-036 The load-use comparator SHALL be one sub-module, load_use_detect, purely combinational.
REQ-037 All counters and FSM registers SHALL be in the top module.

Verification
REQ-038 Load-use: ex_wb_load=1, ex_wb_rd=5, id_rs2=5, id_use_rs2=1 -> exactly one cycle of pc_en=0 and id_ex_flush=1; stall_cycles=1.
REQ-039 rd=x0: same as REQ-038 but ex_wb_rd=0 -> no stall.
REQ-040 Memory wait plus redirect: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect pulsed in cycle 2 -> enables=0 for 3 cycles; on the exit cycle if_id_flush=id_ex_flush=1; flush_count=1; stall_cycles=3.
REQ-041 Multicycle op: ex_mc_start then ex_mc_done 4 cycles later -> ex_mem_flush=1 for 4 cycles, hz_state=2 for those cycles, then RUN.
REQ-042 Saturation: preload stall_cycles near max via force, then stall 3 cycles -> stall_cycles holds at 0xFFFFFFFF.
REQ-043 Reset mid-MC_BUSY: rst_n low for 1 cycle -> hz_state=0, counters=0, and normal flow resumes on the next edge.
